// File: rtl/oal_pkg.sv
// Shared definitions for the operand assembly latch: default widths and the fill-state encoding.
package oal_pkg;

    localparam int unsigned OAL_DATA_W  = 8;
    localparam int unsigned OAL_N_BYTES = 2;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_PARTIAL,
        ST_FULL
    } oal_state_e;

endpackage

// File: rtl/oal_index_adder.sv
// Combinational index add: returns the updated operand and the carry out of lane 0.
module oal_index_adder #(
    parameter int unsigned DATA_W  = oal_pkg::OAL_DATA_W,
    parameter int unsigned N_BYTES = oal_pkg::OAL_N_BYTES,
    parameter int unsigned ZP_WRAP = 1
) (
    input  logic [N_BYTES*DATA_W-1:0] operand,
    input  logic [DATA_W-1:0]         index,
    input  logic                      single_lane,
    output logic [N_BYTES*DATA_W-1:0] sum,
    output logic                      lane0_carry
);

    localparam int unsigned OP_W = N_BYTES * DATA_W;

    logic [OP_W-1:0]   index_ext;
    logic [OP_W-1:0]   wide_sum;
    logic [DATA_W:0]   lane0_sum;

    always_comb begin
        index_ext               = '0;
        index_ext[DATA_W-1:0]   = index;
        wide_sum                = operand + index_ext;
        lane0_sum               = {1'b0, operand[DATA_W-1:0]} + {1'b0, index};
    end

    // Zero-page wrap keeps the upper lanes untouched and never reports a page crossing.
    always_comb begin
        sum         = wide_sum;
        lane0_carry = lane0_sum[DATA_W];
        if ((ZP_WRAP != 0) && single_lane) begin
            sum              = operand;
            sum[DATA_W-1:0]  = lane0_sum[DATA_W-1:0];
            lane0_carry      = 1'b0;
        end
    end

endmodule

// File: rtl/operand_assembly_latch.sv
// Collects operand bytes little-endian from the data bus and applies an optional index add.
module operand_assembly_latch #(
    parameter int unsigned DATA_W  = oal_pkg::OAL_DATA_W,
    parameter int unsigned N_BYTES = oal_pkg::OAL_N_BYTES,
    parameter int unsigned ZP_WRAP = 1
) (
    input  logic                           fclk,
    input  logic                           reset,
    input  logic                           clear,
    input  logic                           load,
    input  logic [DATA_W-1:0]              db_in,
    input  logic                           index_add,
    input  logic [DATA_W-1:0]              index_in,
    output logic [N_BYTES*DATA_W-1:0]      operand_out,
    output logic [DATA_W-1:0]              db_out,
    output logic [$clog2(N_BYTES+1)-1:0]   count_out,
    output logic                           full,
    output logic                           page_cross,
    output logic                           overrun
);

    import oal_pkg::*;

    localparam int unsigned OP_W  = N_BYTES * DATA_W;
    localparam int unsigned CNT_W = $clog2(N_BYTES + 1);

    oal_state_e         state_q, state_d;
    logic [OP_W-1:0]    operand_q;
    logic [CNT_W-1:0]   count_q;
    logic               page_cross_q;
    logic               overrun_q;

    logic               load_ok;
    logic               index_ok;
    logic [OP_W-1:0]    add_sum;
    logic               add_carry;

    // A load in the same cycle always wins over the index add, even if the load is rejected.
    assign load_ok  = load && (state_q != ST_FULL);
    assign index_ok = index_add && !load && (state_q != ST_EMPTY);

    oal_index_adder #(
        .DATA_W  (DATA_W),
        .N_BYTES (N_BYTES),
        .ZP_WRAP (ZP_WRAP)
    ) u_index_adder (
        .operand     (operand_q),
        .index       (index_in),
        .single_lane (count_q == CNT_W'(1)),
        .sum         (add_sum),
        .lane0_carry (add_carry)
    );

    always_ff @(posedge fclk or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_EMPTY;
        end else if (load_ok) begin
            if (count_q == CNT_W'(N_BYTES - 1)) begin
                state_d = ST_FULL;
            end else begin
                state_d = ST_PARTIAL;
            end
        end
    end

    always_ff @(posedge fclk or posedge reset) begin
        if (reset) begin
            operand_q    <= '0;
            count_q      <= '0;
            page_cross_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else if (clear) begin
            operand_q    <= '0;
            count_q      <= '0;
            page_cross_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else if (load) begin
            if (load_ok) begin
                for (int unsigned i = 0; i < N_BYTES; i++) begin
                    if (count_q == CNT_W'(i)) begin
                        operand_q[i*DATA_W +: DATA_W] <= db_in;
                    end
                end
                count_q <= count_q + CNT_W'(1);
            end else begin
                overrun_q <= 1'b1;
            end
        end else if (index_ok) begin
            operand_q    <= add_sum;
            page_cross_q <= add_carry;
        end
    end

    always_comb begin
        operand_out = operand_q;
        db_out      = operand_q[DATA_W-1:0];
        count_out   = count_q;
        full        = (state_q == ST_FULL);
        page_cross  = page_cross_q;
        overrun     = overrun_q;
    end

endmodule

// File: tb/tb_operand_assembly_latch.sv
// Self-checking bench: two latch instances (defaults, and N_BYTES=3 without zero-page wrap) on shared stimulus.
module tb_operand_assembly_latch;

    logic        fclk = 1'b0;
    logic        reset;
    logic        clear;
    logic        load;
    logic [7:0]  db_in;
    logic        index_add;
    logic [7:0]  index_in;

    logic [15:0] op0;
    logic [7:0]  db0;
    logic [1:0]  cnt0;
    logic        full0, pc0, ov0;

    logic [23:0] op3;
    logic [7:0]  db3;
    logic [1:0]  cnt3;
    logic        full3, pc3, ov3;

    int tests = 0;
    int fails = 0;
    bit cmp_en = 0;

    // Reference model state, one slot per instance.
    longint unsigned m_op [2];
    int              m_cnt[2];
    bit              m_pc [2];
    bit              m_ov [2];
    int              nb   [2] = '{2, 3};
    bit              zp   [2] = '{1, 0};

    always #5 fclk = ~fclk;

    operand_assembly_latch u_dut0 (
        .fclk(fclk), .reset(reset), .clear(clear), .load(load), .db_in(db_in),
        .index_add(index_add), .index_in(index_in),
        .operand_out(op0), .db_out(db0), .count_out(cnt0),
        .full(full0), .page_cross(pc0), .overrun(ov0)
    );

    operand_assembly_latch #(.DATA_W(8), .N_BYTES(3), .ZP_WRAP(0)) u_dut3 (
        .fclk(fclk), .reset(reset), .clear(clear), .load(load), .db_in(db_in),
        .index_add(index_add), .index_in(index_in),
        .operand_out(op3), .db_out(db3), .count_out(cnt3),
        .full(full3), .page_cross(pc3), .overrun(ov3)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_op[k] = 0; m_cnt[k] = 0; m_pc[k] = 0; m_ov[k] = 0;
        end
    endtask

    task automatic model_step(input bit c, input bit l, input bit ia,
                              input logic [7:0] d, input logic [7:0] ix);
        longint unsigned lo, wmask;
        for (int k = 0; k < 2; k++) begin
            wmask = (64'd1 << (8 * nb[k])) - 1;
            if (c) begin
                m_op[k] = 0; m_cnt[k] = 0; m_pc[k] = 0; m_ov[k] = 0;
            end else if (l) begin
                if (m_cnt[k] == nb[k]) begin
                    m_ov[k] = 1;
                end else begin
                    m_op[k] = (m_op[k] & ~(64'hFF << (8 * m_cnt[k]))) | (longint'(d) << (8 * m_cnt[k]));
                    m_cnt[k]++;
                end
            end else if (ia && m_cnt[k] >= 1) begin
                lo = (m_op[k] & 64'hFF) + longint'(ix);
                if (zp[k] && m_cnt[k] == 1) begin
                    m_op[k] = (m_op[k] & ~64'hFF) | (lo & 64'hFF);
                    m_pc[k] = 0;
                end else begin
                    m_pc[k] = (lo > 64'hFF);
                    m_op[k] = (m_op[k] + longint'(ix)) & wmask;
                end
            end
        end
    endtask

    // Drive one cycle of strobes; the model advances at the same edge the DUTs sample.
    task automatic tick(input bit c, input bit l, input logic [7:0] d,
                        input bit ia, input logic [7:0] ix);
        clear = c; load = l; db_in = d; index_add = ia; index_in = ix;
        @(posedge fclk);
        model_step(c, l, ia, d, ix);
        @(negedge fclk);
        clear = 0; load = 0; index_add = 0;
    endtask

    always @(negedge fclk) begin
        if (cmp_en) begin
            check("op0",   64'(op0),   m_op[0]);
            check("db0",   64'(db0),   m_op[0] & 64'hFF);
            check("cnt0",  64'(cnt0),  64'(m_cnt[0]));
            check("full0", 64'(full0), 64'(m_cnt[0] == nb[0]));
            check("pc0",   64'(pc0),   64'(m_pc[0]));
            check("ov0",   64'(ov0),   64'(m_ov[0]));
            check("op3",   64'(op3),   m_op[1]);
            check("db3",   64'(db3),   m_op[1] & 64'hFF);
            check("cnt3",  64'(cnt3),  64'(m_cnt[1]));
            check("full3", 64'(full3), 64'(m_cnt[1] == nb[1]));
            check("pc3",   64'(pc3),   64'(m_pc[1]));
            check("ov3",   64'(ov3),   64'(m_ov[1]));
        end
    end

    initial begin
        reset = 1; clear = 0; load = 0; db_in = '0; index_add = 0; index_in = '0;
        model_reset();
        #2;
        check("reset_op0",  64'(op0),  64'h0);
        check("reset_cnt0", 64'(cnt0), 64'h0);
        check("reset_full0",64'(full0),64'h0);
        check("reset_op3",  64'(op3),  64'h0);
        @(negedge fclk);
        @(negedge fclk);
        reset = 0;
        cmp_en = 1;

        // Two loads assemble little-endian.
        tick(0, 1, 8'h34, 0, 8'h00);
        tick(0, 1, 8'h12, 0, 8'h00);
        check("asm_op",   64'(op0),   64'h1234);
        check("asm_full", 64'(full0), 64'h1);
        check("asm_cnt",  64'(cnt0),  64'h2);
        check("asm_db",   64'(db0),   64'h34);

        // Index add with carry out of lane 0, then without.
        tick(1, 0, 8'h00, 0, 8'h00);
        tick(0, 1, 8'hF0, 0, 8'h00);
        tick(0, 1, 8'h12, 0, 8'h00);
        tick(0, 0, 8'h00, 1, 8'h20);
        check("idx_op1", 64'(op0), 64'h1310);
        check("idx_pc1", 64'(pc0), 64'h1);
        tick(0, 0, 8'h00, 1, 8'h01);
        check("idx_op2", 64'(op0), 64'h1311);
        check("idx_pc2", 64'(pc0), 64'h0);

        // Single-byte operand: wrap within lane 0 on dut0, carry into lane 1 on dut3.
        tick(1, 0, 8'h00, 0, 8'h00);
        tick(0, 1, 8'hF0, 0, 8'h00);
        tick(0, 0, 8'h00, 1, 8'h20);
        check("zp_op",   64'(op0),  64'h0010);
        check("zp_pc",   64'(pc0),  64'h0);
        check("zp_cnt",  64'(cnt0), 64'h1);
        check("nozp_op", 64'(op3),  64'h000110);
        check("nozp_pc", 64'(pc3),  64'h1);

        // Overrun while full, then clear.
        tick(1, 0, 8'h00, 0, 8'h00);
        tick(0, 1, 8'h34, 0, 8'h00);
        tick(0, 1, 8'h12, 0, 8'h00);
        tick(0, 1, 8'h56, 0, 8'h00);
        check("ovr_op", 64'(op0), 64'h1234);
        check("ovr_ov", 64'(ov0), 64'h1);
        tick(1, 0, 8'h00, 0, 8'h00);
        check("clr_op",  64'(op0),  64'h0);
        check("clr_ov",  64'(ov0),  64'h0);
        check("clr_cnt", 64'(cnt0), 64'h0);

        // Strobe priority.
        tick(0, 1, 8'h34, 0, 8'h00);
        tick(1, 1, 8'h55, 1, 8'h07);
        check("prio_clr_op",  64'(op0),  64'h0);
        check("prio_clr_cnt", 64'(cnt0), 64'h0);
        tick(0, 1, 8'h34, 0, 8'h00);
        tick(0, 1, 8'h12, 1, 8'h05);
        check("prio_ld_op", 64'(op0), 64'h1234);
        tick(0, 1, 8'h99, 1, 8'h05);
        check("prio_rej_op", 64'(op0), 64'h1234);
        check("prio_rej_ov", 64'(ov0), 64'h1);

        // Asynchronous reset mid-assembly.
        tick(1, 0, 8'h00, 0, 8'h00);
        tick(0, 1, 8'h01, 0, 8'h00);
        tick(0, 1, 8'h02, 0, 8'h00);
        #2;
        reset = 1;
        model_reset();
        #1;
        check("async_op3",  64'(op3),  64'h0);
        check("async_cnt3", 64'(cnt3), 64'h0);
        check("async_op0",  64'(op0),  64'h0);
        @(negedge fclk);
        reset = 0;
        tick(0, 1, 8'hAA, 0, 8'h00);
        check("post_rst_op3",  64'(op3),  64'h0000AA);
        check("post_rst_cnt3", 64'(cnt3), 64'h1);

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            tick(($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 2) == 0),
                 8'($urandom),
                 ($urandom_range(0, 1) == 1),
                 8'($urandom));
        end

        cmp_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/operand_assembly_latch.md
OPERAND_ASSEMBLY_LATCH -- requirements
Module: operand_assembly_latch

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the bus byte width (legal range 4..16).
REQ-002 Parameter N_BYTES, default 2, SHALL set the number of operand bytes collected (legal range 1..4).
REQ-003 Parameter ZP_WRAP, default 1, SHALL enable zero-page wrap for single-byte operands during an index add (0 = disabled).
REQ-004 fclk  in  1  SHALL be the single clock; all state updates occur on the rising edge.
REQ-005 reset  in  1  SHALL be the asynchronous, active-high reset.
REQ-006 clear  in  1  SHALL be a synchronous clear of operand, count and flags.
REQ-007 load  in  1  SHALL be a byte strobe that captures db_in into the next free byte lane.
REQ-008 db_in  in  DATA_W  SHALL be the data bus byte.
REQ-009 index_add  in  1  SHALL be a strobe that adds index_in to the assembled operand.
REQ-010 index_in  in  DATA_W  SHALL be the index register value (X or Y).
REQ-011 operand_out  out  N_BYTES*DATA_W  SHALL be the assembled operand, lane N_BYTES-1 in the MSBs and lane 0 in the LSBs.
REQ-012 db_out  out  DATA_W  SHALL be lane 0.
REQ-013 count_out  out  $clog2(N_BYTES+1)  SHALL be the number of lanes loaded.
REQ-014 full  out  1  SHALL be high when count_out equals N_BYTES.
REQ-015 page_cross  out  1  SHALL flag a carry out of lane 0 on the last accepted index add.
REQ-016 overrun  out  1  SHALL be a sticky flag for a load attempted while full.

Function
REQ-017 States SHALL be EMPTY (count 0), PARTIAL (0 < count < N_BYTES) and FULL (count = N_BYTES); when N_BYTES=1, PARTIAL is unreachable.
REQ-018 Lanes SHALL fill little-endian: the first load writes lane 0, and each subsequent load writes lane count.
REQ-019 An accepted load SHALL write the lane and increment the count, with the result visible the cycle after the strobe (1-cycle latency).
REQ-020 On the load that makes count = N_BYTES, the state SHALL move to FULL and full SHALL assert the next cycle.
REQ-021 A load in FULL SHALL be ignored (lanes and count unchanged) and SHALL set overrun until clear or reset.
REQ-022 An index_add with count >= 1 SHALL replace the operand with (operand + zero-extended index_in) mod 2^(N_BYTES*DATA_W); the count SHALL be unchanged.
REQ-023 When count = 1 and ZP_WRAP=1, an index_add SHALL change only lane 0, mod 2^DATA_W, and SHALL force page_cross to 0.
REQ-024 page_cross SHALL be updated on every accepted index_add to the carry out of lane 0, and SHALL hold otherwise.
REQ-025 An index_add with count = 0 SHALL be ignored.
REQ-026 Priority SHALL be clear > load > index_add; an index_add in the same cycle as an accepted or rejected load SHALL be dropped.
REQ-027 clear SHALL zero all lanes, count, page_cross and overrun on the next edge, regardless of other strobes.
REQ-028 Lanes not yet loaded SHALL read as 0.

Reset
REQ-029 While reset is high, operand_out, db_out, count_out, full, page_cross and overrun SHALL be 0 and the state SHALL be EMPTY, with no clock required.
REQ-030 Reset asserted mid-assembly SHALL discard the partial operand; the first load after release SHALL write lane 0.

Structure
REQ-031 The state enum (EMPTY/PARTIAL/FULL) and the default DATA_W and N_BYTES constants SHALL reside in shared package oal_pkg.
REQ-032 The index add SHALL be one combinational sub-module, oal_index_adder, that returns the sum and the lane-0 carry; all state SHALL be held in flip-flops, with no latches.

Verification
REQ-033 Defaults: load 0x34, then load 0x12 -> operand_out=0x1234, full=1, count_out=2, db_out=0x34.
REQ-034 Defaults: operand 0x12F0, index_add with index_in=0x20 -> operand_out=0x1310, page_cross=1; then index_in=0x01 -> 0x1311, page_cross=0.
REQ-035 ZP_WRAP=1: a single load 0xF0, then index_add 0x20 -> operand_out=0x0010, page_cross=0, count_out=1.
REQ-036 Defaults: FULL at 0x1234, load 0x56 -> operand unchanged, overrun=1; then clear -> all outputs 0.
REQ-037 Defaults: clear+load+index_add in the same cycle -> all zero; load+index_add in the same cycle -> only the load takes effect.
REQ-038 N_BYTES=3: load 0x01, then load 0x02, then assert reset asynchronously between edges -> outputs 0 immediately; after release, load 0xAA -> operand_out=0x0000AA.
